// File: rtl/agent_banked_memory_controller.sv
// agent_banked_memory_controller
//   Routes one agent memory port to either a set of banked single-port local SRAMs
//   (shared address/data bus, per-bank chip select) or the arbitrated main memory.
//   Local accesses complete at one per cycle. Main accesses wait for the arbiter grant.
//   Unmapped addresses return an error pulse, plus a zero read-data pulse for reads.
//
// Optional feature (macro AGENT_MEMCTRL_GRANT_TIMEOUT_EN):
//   Abort a main access after GRANT_TIMEOUT ungranted wait cycles and report an error.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mem_ctrl_req/we/addr/in  agent request (accepted when req && rdy at a rising edge)
//   mem_ctrl_rdy             controller can accept a request this cycle
//   mem_ctrl_rvld            one-cycle pulse, mem_ctrl_out holds read data
//   mem_ctrl_out             read data, held until the next rvld
//   mem_ctrl_err             one-cycle pulse: unmapped access or grant timeout
//   main_mem_*               main-memory arbitration request / grant and access bus
//   sram_csb0/web0           per-bank active-low chip select / write enable
//   sram_comm_addr0/din0     shared bank address / write data
//   sram_dout0               concatenated bank read data (bank k at [k*DATA_W +: DATA_W])
module agent_banked_memory_controller #(
   parameter int unsigned            NUM_BANKS      = 5,
   parameter int unsigned            BANK_ADDR_BITS = 9,
   parameter int unsigned            DATA_W         = 32,
   parameter int unsigned            CTRL_ADDR_W    = 14,
   parameter int unsigned            MAIN_ADDR_W    = 8,
   parameter logic [CTRL_ADDR_W-1:0] MAIN_BASE      = 14'h2000,
   parameter int unsigned            GRANT_TIMEOUT  = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mem_ctrl_req,
   input  logic                          mem_ctrl_we,
   input  logic [CTRL_ADDR_W-1:0]        mem_ctrl_addr,
   input  logic [DATA_W-1:0]             mem_ctrl_in,
   output logic                          mem_ctrl_rdy,
   output logic                          mem_ctrl_rvld,
   output logic [DATA_W-1:0]             mem_ctrl_out,
   output logic                          mem_ctrl_err,
   output logic                          main_mem_req,
   input  logic                          main_mem_grant,
   output logic                          main_mem_we,
   output logic [MAIN_ADDR_W-1:0]        main_mem_addr,
   output logic [DATA_W-1:0]             main_mem_in,
   input  logic [DATA_W-1:0]             main_mem_out,
   output logic [NUM_BANKS-1:0]          sram_csb0,
   output logic [NUM_BANKS-1:0]          sram_web0,
   input  logic [NUM_BANKS*DATA_W-1:0]   sram_dout0,
   output logic [BANK_ADDR_BITS-1:0]     sram_comm_addr0,
   output logic [DATA_W-1:0]             sram_comm_din0
);

   if (NUM_BANKS < 1 || NUM_BANKS > 8 || GRANT_TIMEOUT < 1) begin : g_bad_param
      $error("agent_banked_memory_controller: NUM_BANKS must be 1..8, GRANT_TIMEOUT >= 1");
   end

   // One extra bit so the window limits cannot wrap.
   localparam logic [CTRL_ADDR_W:0] LOCAL_LIM =
      (CTRL_ADDR_W+1)'(NUM_BANKS << BANK_ADDR_BITS);
   localparam logic [CTRL_ADDR_W:0] MAIN_LO = {1'b0, MAIN_BASE};
   localparam logic [CTRL_ADDR_W:0] MAIN_HI = MAIN_LO + (CTRL_ADDR_W+1)'(1 << MAIN_ADDR_W);

   typedef enum logic [1:0] {StIdle, StMainWait, StMainResp} state_e;

   state_e                   state_q, state_d;
   logic                     lat_we_q, lat_we_d;
   logic [MAIN_ADDR_W-1:0]   lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0]        lat_data_q, lat_data_d;
   logic                     loc_rvld_q, loc_rvld_d;   // local read data due this cycle
   logic                     zero_rvld_q, zero_rvld_d; // error read: return zero data
   logic [2:0]               bank_q, bank_d;
   logic                     err_q, err_d;
   logic [DATA_W-1:0]        out_q;

   logic [CTRL_ADDR_W:0]     addr_ext;
   logic                     is_local, is_main, accept, timeout_hit;
   logic [2:0]               bank_sel;
   logic [MAIN_ADDR_W-1:0]   main_off;

   always_comb begin
      addr_ext = {1'b0, mem_ctrl_addr};
      is_local = addr_ext < LOCAL_LIM;
      is_main  = (addr_ext >= MAIN_LO) && (addr_ext < MAIN_HI);
      bank_sel = mem_ctrl_addr[BANK_ADDR_BITS+2:BANK_ADDR_BITS];
      main_off = MAIN_ADDR_W'(mem_ctrl_addr - MAIN_BASE);
   end

   assign mem_ctrl_rdy = rst && (state_q == StIdle);
   assign accept       = mem_ctrl_req && mem_ctrl_rdy;

`ifdef AGENT_MEMCTRL_GRANT_TIMEOUT_EN
   localparam int unsigned CNT_W =
      ($clog2(GRANT_TIMEOUT + 1) > 8) ? $clog2(GRANT_TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] wait_cnt_q;

   // Counts ungranted wait cycles; held at zero outside the wait so it is clear on entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q <= '0;
      end else if (state_q != StMainWait) begin
         wait_cnt_q <= '0;
      end else if (!main_mem_grant) begin
         wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
   end

   // A grant in the expiry cycle still wins.
   assign timeout_hit = (state_q == StMainWait) && !main_mem_grant &&
                        (wait_cnt_q == CNT_W'(GRANT_TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      lat_we_d        = lat_we_q;
      lat_addr_d      = lat_addr_q;
      lat_data_d      = lat_data_q;
      loc_rvld_d      = 1'b0;
      zero_rvld_d     = 1'b0;
      bank_d          = bank_q;
      err_d           = 1'b0;
      sram_csb0       = '1;
      sram_web0       = '1;
      sram_comm_addr0 = '0;
      sram_comm_din0  = '0;
      main_mem_req    = 1'b0;
      main_mem_we     = 1'b0;
      main_mem_addr   = '0;
      main_mem_in     = '0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_local) begin
                  for (int unsigned k = 0; k < NUM_BANKS; k++) begin
                     sram_csb0[k] = (bank_sel != 3'(k));
                     sram_web0[k] = !(mem_ctrl_we && (bank_sel == 3'(k)));
                  end
                  sram_comm_addr0 = mem_ctrl_addr[BANK_ADDR_BITS-1:0];
                  sram_comm_din0  = mem_ctrl_in;
                  loc_rvld_d      = !mem_ctrl_we;
                  bank_d          = bank_sel;
               end else if (is_main) begin
                  main_mem_req = 1'b1;
                  lat_we_d     = mem_ctrl_we;
                  lat_addr_d   = main_off;
                  lat_data_d   = mem_ctrl_in;
                  state_d      = StMainWait;
               end else begin
                  err_d       = 1'b1;
                  zero_rvld_d = !mem_ctrl_we;
               end
            end
         end
         StMainWait: begin
            main_mem_req = 1'b1;
            if (main_mem_grant) begin
               main_mem_we   = lat_we_q;
               main_mem_addr = lat_addr_q;
               main_mem_in   = lat_data_q;
               state_d       = lat_we_q ? StIdle : StMainResp;
            end else if (timeout_hit) begin
               err_d       = 1'b1;
               zero_rvld_d = !lat_we_q;
               state_d     = StIdle;
            end
         end
         StMainResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Read data is steered combinationally in the rvld cycle and captured at its end.
   always_comb begin
      mem_ctrl_out = out_q;
      if (loc_rvld_q) begin
         for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (bank_q == 3'(k)) mem_ctrl_out = sram_dout0[k*DATA_W +: DATA_W];
         end
      end
      if (zero_rvld_q) mem_ctrl_out = '0;
      if (state_q == StMainResp) mem_ctrl_out = main_mem_out;
   end

   assign mem_ctrl_rvld = loc_rvld_q || zero_rvld_q || (state_q == StMainResp);
   assign mem_ctrl_err  = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_data_q  <= '0;
         loc_rvld_q  <= 1'b0;
         zero_rvld_q <= 1'b0;
         bank_q      <= '0;
         err_q       <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_data_q  <= lat_data_d;
         loc_rvld_q  <= loc_rvld_d;
         zero_rvld_q <= zero_rvld_d;
         bank_q      <= bank_d;
         err_q       <= err_d;
         out_q       <= mem_ctrl_out;
      end
   end

endmodule
